gf_mul_seq: RTL and testbench

//  Iterative GF(2^W) multiplier with valid/ready handshake, successor to the combinational gal8_mul.

---
 rtl/gf_pkg.sv | 26 ++
 rtl/gf_horner_step.sv | 27 ++
 rtl/gf_mul_seq.sv | 114 +++++++++++
 tb/tb_gf_mul_seq.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/gf_pkg.sv
// Shared GF(2^W) constants, FSM state type and the xtime helper used by the
// sequential multiplier.
package gf_pkg;

  localparam logic [7:0] AES_POLY  = 8'h1B;
  localparam logic [3:0] GF16_POLY = 4'h3;
  localparam int         GF_MAX_W  = 32;

  typedef enum logic [1:0] {IDLE, RUN, DONE} gf_state_e;

  // Multiply v by x modulo (x^w + poly); operands are zero-extended to GF_MAX_W.
  function automatic logic [GF_MAX_W-1:0] gf_xtime(
    input logic [GF_MAX_W-1:0] v,
    input logic [GF_MAX_W-1:0] poly,
    input int                  w
  );
    logic [GF_MAX_W-1:0] mask;
    logic [GF_MAX_W-1:0] shl;
    logic                top;
    mask = (w >= GF_MAX_W) ? '1 : ((GF_MAX_W'(1) << w) - GF_MAX_W'(1));
    top  = |(v & (GF_MAX_W'(1) << (w - 1)));
    shl  = (v << 1) & mask;
    return top ? (shl ^ (poly & mask)) : shl;
  endfunction

endpackage

// File: rtl/gf_horner_step.sv
// One MSB-first Horner step: acc' = xtime(acc) ^ (bbit ? a : 0).
module gf_horner_step
  import gf_pkg::*;
#(
  parameter int             W    = 8,
  parameter logic [W-1:0]   POLY = W'(AES_POLY)
) (
  input  logic [W-1:0] i_acc,
  input  logic [W-1:0] i_a,
  input  logic         i_bbit,
  output logic [W-1:0] o_acc
);

  logic [GF_MAX_W-1:0] w_xt;

  assign w_xt  = gf_xtime(GF_MAX_W'(i_acc), GF_MAX_W'(POLY), W);
  assign o_acc = w_xt[W-1:0] ^ (i_bbit ? i_a : '0);

  // The helper masks to W bits, so the upper bits are always zero.
  generate
    if (W < GF_MAX_W) begin : g_hi
      logic w_unused_hi;
      assign w_unused_hi = |w_xt[GF_MAX_W-1:W];
    end
  endgenerate

endmodule

// File: rtl/gf_mul_seq.sv
// Iterative GF(2^W) multiplier: DIGIT bits of b per cycle, MSB-first Horner,
// with valid/ready on both sides and back-to-back accept from DONE.
module gf_mul_seq
  import gf_pkg::*;
#(
  parameter int           W     = 8,
  parameter logic [W-1:0] POLY  = W'(AES_POLY),
  parameter int           DIGIT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] res,
  output logic         busy
);

  localparam int STEPS = W / DIGIT;
  localparam int CW    = $clog2(STEPS + 1);

  generate
    if (W < 2 || W > GF_MAX_W || DIGIT < 1 || (W % DIGIT) != 0) begin : g_bad_params
      $error("gf_mul_seq: W must be in [2,%0d] and divisible by DIGIT", GF_MAX_W);
    end
  endgenerate

  gf_state_e     r_state;
  gf_state_e     w_state_next;
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic [W-1:0]  r_acc;
  logic [W-1:0]  r_res;
  logic [CW-1:0] r_count;
  logic          w_accept;
  logic          w_last;
  logic [W-1:0]  w_chain [DIGIT+1];

  // Chain of DIGIT Horner steps; step gi consumes the gi-th remaining MSB of b.
  assign w_chain[0] = r_acc;
  generate
    for (genvar gi = 0; gi < DIGIT; gi++) begin : g_step
      gf_horner_step #(
        .W    (W),
        .POLY (POLY)
      ) u_step (
        .i_acc  (w_chain[gi]),
        .i_a    (r_a),
        .i_bbit (r_b[W-1-gi]),
        .o_acc  (w_chain[gi+1])
      );
    end
  endgenerate

  assign w_last = (r_count == CW'(1));
  assign res    = r_res;

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    busy         = 1'b0;
    w_accept     = 1'b0;
    unique case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        w_accept = in_valid;
        if (in_valid) w_state_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (w_last) w_state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        w_accept  = in_valid & out_ready;
        if (w_accept)       w_state_next = RUN;
        else if (out_ready) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // res is a separate register so it survives the acc clear of the next accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_res   <= '0;
      r_count <= '0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= b;
      r_acc   <= '0;
      r_count <= CW'(STEPS);
    end else if (r_state == RUN) begin
      r_acc   <= w_chain[DIGIT];
      r_b     <= r_b << DIGIT;
      r_count <= r_count - CW'(1);
      if (w_last) r_res <= w_chain[DIGIT];
    end
  end

endmodule

// File: tb/tb_gf_mul_seq.sv
// Self-checking bench: four gf_mul_seq configurations checked every cycle against
// a carry-less-multiply-then-reduce model, plus directed FIPS-197 style cases.
module tb_gf_mul_seq;
  import gf_pkg::*;

  localparam int N = 4;
  localparam int KW     [N] = '{8, 8, 8, 4};
  localparam int KSTEPS [N] = '{8, 2, 1, 4};
  localparam logic [7:0] KPOLY [N] = '{AES_POLY, AES_POLY, AES_POLY, {4'h0, GF16_POLY}};

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sv_valid [N];
  logic       sv_ordy  [N];
  logic [7:0] sv_a     [N];
  logic [7:0] sv_b     [N];
  wire        sv_ir    [N];
  wire        sv_ov    [N];
  wire        sv_busy  [N];
  wire  [7:0] sv_res   [N];
  wire  [3:0] w4_res;

  int total = 0;
  int bad   = 0;

  bit         m_inflight [N];
  bit         m_valid    [N];
  int         m_rem      [N];
  logic [7:0] m_res      [N];
  logic [7:0] m_next     [N];

  always #5 clk = ~clk;

  gf_mul_seq #(.W(8), .POLY(8'h1B), .DIGIT(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(sv_valid[0]), .in_ready(sv_ir[0]),
    .a(sv_a[0]), .b(sv_b[0]), .out_valid(sv_ov[0]), .out_ready(sv_ordy[0]),
    .res(sv_res[0]), .busy(sv_busy[0]));

  gf_mul_seq #(.W(8), .POLY(8'h1B), .DIGIT(4)) u_d4 (
    .clk(clk), .rst_n(rst_n), .in_valid(sv_valid[1]), .in_ready(sv_ir[1]),
    .a(sv_a[1]), .b(sv_b[1]), .out_valid(sv_ov[1]), .out_ready(sv_ordy[1]),
    .res(sv_res[1]), .busy(sv_busy[1]));

  gf_mul_seq #(.W(8), .POLY(8'h1B), .DIGIT(8)) u_d8 (
    .clk(clk), .rst_n(rst_n), .in_valid(sv_valid[2]), .in_ready(sv_ir[2]),
    .a(sv_a[2]), .b(sv_b[2]), .out_valid(sv_ov[2]), .out_ready(sv_ordy[2]),
    .res(sv_res[2]), .busy(sv_busy[2]));

  gf_mul_seq #(.W(4), .POLY(GF16_POLY), .DIGIT(1)) u_w4 (
    .clk(clk), .rst_n(rst_n), .in_valid(sv_valid[3]), .in_ready(sv_ir[3]),
    .a(sv_a[3][3:0]), .b(sv_b[3][3:0]), .out_valid(sv_ov[3]), .out_ready(sv_ordy[3]),
    .res(w4_res), .busy(sv_busy[3]));

  assign sv_res[3] = {4'h0, w4_res};

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%h want=%h", name, $time, act, exp);
    end
  endtask

  function automatic logic [7:0] msk(input int k);
    return (KW[k] == 8) ? 8'hFF : 8'h0F;
  endfunction

  // Full carry-less product, then long division by x^w + poly.
  function automatic logic [7:0] ref_mul(input logic [7:0] x, input logic [7:0] y,
                                         input int w, input logic [7:0] poly);
    logic [15:0] p;
    logic [15:0] m;
    p = 16'h0;
    m = 16'(poly) | (16'd1 << w);
    for (int i = 0; i < w; i++)
      if (y[i]) p = p ^ (16'(x) << i);
    for (int i = 2 * w - 2; i >= w; i--)
      if (p[i]) p = p ^ (m << (i - w));
    return p[7:0];
  endfunction

  task automatic monitor();
    forever begin
      @(negedge clk);
      for (int k = 0; k < N; k++) begin
        logic exp_ir;
        logic acc;
        if (!rst_n) begin
          m_inflight[k] = 1'b0;
          m_valid[k]    = 1'b0;
          m_rem[k]      = 0;
          m_res[k]      = 8'h00;
          check($sformatf("rst_ov%0d", k), 8'(sv_ov[k]), 8'd0);
          check($sformatf("rst_res%0d", k), sv_res[k], 8'h00);
          check($sformatf("rst_busy%0d", k), 8'(sv_busy[k]), 8'd0);
        end else begin
          exp_ir = !m_inflight[k] && (!m_valid[k] || sv_ordy[k]);
          check($sformatf("mon_ov%0d", k), 8'(sv_ov[k]), 8'(m_valid[k]));
          check($sformatf("mon_busy%0d", k), 8'(sv_busy[k]), 8'(m_inflight[k]));
          check($sformatf("mon_ir%0d", k), 8'(sv_ir[k]), 8'(exp_ir));
          check($sformatf("mon_res%0d", k), sv_res[k], m_res[k]);
          acc = sv_valid[k] && exp_ir;
          if (m_inflight[k]) begin
            m_rem[k] = m_rem[k] - 1;
            if (m_rem[k] == 0) begin
              m_inflight[k] = 1'b0;
              m_valid[k]    = 1'b1;
              m_res[k]      = m_next[k];
            end
          end else if (m_valid[k] && sv_ordy[k]) begin
            m_valid[k] = 1'b0;
          end
          if (acc) begin
            m_inflight[k] = 1'b1;
            m_rem[k]      = KSTEPS[k];
            m_next[k]     = ref_mul(sv_a[k] & msk(k), sv_b[k] & msk(k), KW[k], KPOLY[k]);
          end
        end
      end
    end
  endtask

  // Starts and ends at posedge+1 with the DUT idle and out_ready low.
  task automatic run_op(input int k, input logic [7:0] x, input logic [7:0] y,
                        input logic [7:0] exp, input int hold);
    int n;
    sv_a[k] = x; sv_b[k] = y; sv_valid[k] = 1'b1; sv_ordy[k] = 1'b0;
    n = 0;
    while (!sv_ir[k] && n < 50) begin @(posedge clk); #1; n++; end
    check($sformatf("acc_timeout%0d", k), 8'(n < 50), 8'd1);
    @(posedge clk); #1;
    sv_valid[k] = 1'b0; sv_a[k] = 8'($urandom); sv_b[k] = 8'($urandom);
    n = 0;
    while (!sv_ov[k] && n < 50) begin @(posedge clk); #1; n++; end
    check($sformatf("latency%0d_%h_%h", k, x, y), 8'(n), 8'(KSTEPS[k]));
    check($sformatf("res%0d_%h_%h", k, x, y), sv_res[k], exp);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check($sformatf("hold_ov%0d", k), 8'(sv_ov[k]), 8'd1);
      check($sformatf("hold_res%0d", k), sv_res[k], exp);
      check($sformatf("hold_ir%0d", k), 8'(sv_ir[k]), 8'd0);
    end
    sv_ordy[k] = 1'b1;
    @(posedge clk); #1;
    sv_ordy[k] = 1'b0;
    check($sformatf("drain_ov%0d", k), 8'(sv_ov[k]), 8'd0);
    check($sformatf("keep_res%0d", k), sv_res[k], exp);
  endtask

  initial begin
    int t_first;
    int t_second;
    rst_n = 1'b0;
    for (int k = 0; k < N; k++) begin
      sv_valid[k] = 1'b0; sv_ordy[k] = 1'b0; sv_a[k] = 8'h00; sv_b[k] = 8'h00;
    end
    fork monitor(); join_none

    check("model_57x83", ref_mul(8'h57, 8'h83, 8, 8'h1B), 8'hC1);
    check("model_57x13", ref_mul(8'h57, 8'h13, 8, 8'h1B), 8'hFE);
    check("model_53xCA", ref_mul(8'h53, 8'hCA, 8, 8'h1B), 8'h01);
    check("model_9xB",   ref_mul(8'h09, 8'h0B, 4, 8'h03), 8'h0C);

    repeat (2) @(posedge clk);
    #1;
    check("reset_ov", 8'(sv_ov[0]), 8'd0);
    check("reset_res", sv_res[0], 8'h00);
    check("reset_busy", 8'(sv_busy[0]), 8'd0);
    check("reset_ir", 8'(sv_ir[0]), 8'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(0, 8'h57, 8'h83, 8'hC1, 5);
    run_op(0, 8'h57, 8'h13, 8'hFE, 0);
    run_op(0, 8'h53, 8'hCA, 8'h01, 1);
    run_op(0, 8'h00, 8'hFF, 8'h00, 0);
    run_op(0, 8'hA5, 8'h01, 8'hA5, 0);
    run_op(1, 8'h57, 8'h83, 8'hC1, 2);
    run_op(1, 8'h02, 8'h87, 8'h15, 0);
    run_op(2, 8'h53, 8'hCA, 8'h01, 0);
    run_op(3, 8'h09, 8'h0B, 8'h0C, 1);

    // Abort an operation in its third RUN cycle.
    sv_a[0] = 8'h57; sv_b[0] = 8'h83; sv_valid[0] = 1'b1;
    @(posedge clk); #1;
    sv_valid[0] = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    check("midrun_busy", 8'(sv_busy[0]), 8'd1);
    rst_n = 1'b0;
    #1;
    check("abort_ov", 8'(sv_ov[0]), 8'd0);
    check("abort_res", sv_res[0], 8'h00);
    check("abort_busy", 8'(sv_busy[0]), 8'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(0, 8'h02, 8'h87, 8'h15, 0);

    // Back-to-back throughput with in_valid held and out_ready high.
    t_first = -1; t_second = -1;
    sv_ordy[0] = 1'b1; sv_valid[0] = 1'b1;
    for (int c = 0; c < 40; c++) begin
      sv_a[0] = 8'($urandom); sv_b[0] = 8'($urandom);
      @(posedge clk); #1;
      if (sv_ov[0]) begin
        if (t_first < 0) t_first = c;
        else if (t_second < 0) t_second = c;
      end
    end
    check("b2b_period", 8'(t_second - t_first), 8'(KSTEPS[0] + 1));
    sv_valid[0] = 1'b0;
    repeat (12) begin @(posedge clk); #1; end
    sv_ordy[0] = 1'b0;

    for (int c = 0; c < 1500; c++) begin
      for (int k = 0; k < N; k++) begin
        int sel;
        sv_valid[k] = 1'($urandom_range(0, 1));
        sv_ordy[k]  = ($urandom_range(0, 3) != 0);
        sel = int'($urandom_range(0, 7));
        sv_a[k] = (sel == 0) ? 8'h00 : (sel == 1) ? 8'h01 : 8'($urandom);
        sel = int'($urandom_range(0, 7));
        sv_b[k] = (sel == 0) ? 8'h00 : (sel == 1) ? 8'h01 : 8'($urandom);
      end
      @(posedge clk); #1;
    end
    for (int k = 0; k < N; k++) begin sv_valid[k] = 1'b0; sv_ordy[k] = 1'b1; end
    repeat (20) begin @(posedge clk); #1; end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
